// File: rtl/thor2022_livetarget_trk_if.sv
// Rename-side interface of the Thor2022 live-target tracker: allocation,
// retirement, branch-miss recovery, rename lookup and live bitmaps.
interface thor2022_livetarget_trk_if #(
  parameter int REB_ENTRIES = 8,
  parameter int NREGS       = 32,
  parameter int NCREGS      = 16,
  parameter int TAGW        = $clog2(REB_ENTRIES)
);
  // alloc_i is a request qualified by alloc_rdy_o: an entry is allocated only on a
  // clock edge where both are high; alloc_tag_o names the entry taken on that edge.
  logic                      alloc_i;
  logic [$clog2(NREGS)-1:0]  alloc_rt_i;
  logic [$clog2(NCREGS)-1:0] alloc_ct_i;
  logic                      alloc_rdy_o;
  logic [TAGW-1:0]           alloc_tag_o;
  logic                      cmt_i;
  logic                      miss_i;
  logic [TAGW-1:0]           missid_i;
  logic [$clog2(NREGS)-1:0]  lk_reg_i;
  logic                      lk_valid_o;
  logic [TAGW-1:0]           lk_tag_o;
  logic [NREGS-1:0]          livetarget_o;
  logic [NCREGS-1:0]         ca_livetarget_o;
  logic                      busy_o;
  logic [TAGW:0]             count_o;
  logic                      state_o;

  modport slave (
    input  alloc_i, alloc_rt_i, alloc_ct_i, cmt_i, miss_i, missid_i, lk_reg_i,
    output alloc_rdy_o, alloc_tag_o, lk_valid_o, lk_tag_o, livetarget_o,
           ca_livetarget_o, busy_o, count_o, state_o
  );

  modport master (
    output alloc_i, alloc_rt_i, alloc_ct_i, cmt_i, miss_i, missid_i, lk_reg_i,
    input  alloc_rdy_o, alloc_tag_o, lk_valid_o, lk_tag_o, livetarget_o,
           ca_livetarget_o, busy_o, count_o, state_o
  );
endinterface

// File: rtl/thor2022_livetarget_trk.sv
// Live-target tracker: youngest-producer maps for GPR/Ct targets with walk-based
// miss recovery. Define THOR2022_LT_FASTRECOVER_EN for single-cycle recovery.
module thor2022_livetarget_trk #(
  parameter int REB_ENTRIES = 8,
  parameter int NREGS       = 32,
  parameter int NCREGS      = 16,
  parameter int TAGW        = $clog2(REB_ENTRIES)
) (
  input  logic clk_i,
  input  logic rst_i,
  thor2022_livetarget_trk_if.slave bus
);
  localparam int RW = $clog2(NREGS);
  localparam int CW = $clog2(NCREGS);

  typedef enum logic {S_IDLE = 1'b0, S_WALK = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [REB_ENTRIES-1:0] r_v;
  logic [RW-1:0]     r_rt [REB_ENTRIES];
  logic [CW-1:0]     r_ct [REB_ENTRIES];
  logic [TAGW-1:0]   r_head, r_tail, r_ptr, r_missid;
  logic [TAGW:0]     r_count;
  logic [NREGS-1:0]  r_mv, r_lt;
  logic [TAGW-1:0]   r_mtag [NREGS];
  logic [NCREGS-1:0] r_cmv, r_clt;
  logic [TAGW-1:0]   r_cmtag [NCREGS];

  logic              w_alloc_rdy, w_alloc_take, w_cmt_take, w_miss_hit;
  logic              w_walk_act, w_walk_ins;
  logic [TAGW-1:0]   w_miss_off, w_rt_tag_eff, w_ct_tag_eff;
  logic [RW-1:0]     w_h_rt;
  logic [CW-1:0]     w_h_ct;
  logic [REB_ENTRIES-1:0] w_kill;

  assign w_alloc_rdy  = (r_state == S_IDLE) && (r_count < (TAGW+1)'(REB_ENTRIES)) && !bus.miss_i;
  assign w_alloc_take = bus.alloc_i && w_alloc_rdy;
  assign w_cmt_take   = bus.cmt_i && (r_count != '0);
  // A miss counts only if its tag is occupied: circular offset from head below count.
  assign w_miss_off   = bus.missid_i - r_head;
  assign w_miss_hit   = bus.miss_i && ({1'b0, w_miss_off} < r_count);
  assign w_walk_act   = (r_state == S_WALK) && !w_miss_hit;
  assign w_walk_ins   = w_walk_act && r_v[r_ptr];

  assign w_h_rt = r_rt[r_head];
  assign w_h_ct = r_ct[r_head];
  // The retire-clear compares against the tag after this cycle's walk insert.
  assign w_rt_tag_eff = (w_walk_ins && r_rt[r_ptr] == w_h_rt) ? r_ptr : r_mtag[w_h_rt];
  assign w_ct_tag_eff = (w_walk_ins && r_ct[r_ptr] == w_h_ct) ? r_ptr : r_cmtag[w_h_ct];

  always_comb begin
    w_kill = '0;
    for (int i = 0; i < REB_ENTRIES; i++) begin
      logic [TAGW-1:0] off;
      off = TAGW'(i) - r_head;
      w_kill[i] = ({1'b0, off} < r_count) && (off > w_miss_off);
    end
  end

`ifdef THOR2022_LT_FASTRECOVER_EN
  logic [NREGS-1:0]  w_fr_mv;
  logic [TAGW-1:0]   w_fr_mtag [NREGS];
  logic [NCREGS-1:0] w_fr_cmv;
  logic [TAGW-1:0]   w_fr_cmtag [NCREGS];

  // Oldest-to-missid scan; later entries overwrite, a retiring head is excluded.
  always_comb begin
    w_fr_mv    = '0;
    w_fr_mtag  = r_mtag;
    w_fr_cmv   = '0;
    w_fr_cmtag = r_cmtag;
    for (int i = 0; i < REB_ENTRIES; i++) begin
      logic [TAGW-1:0] idx;
      idx = r_head + TAGW'(i);
      if (TAGW'(i) <= w_miss_off && r_v[idx] && !(w_cmt_take && i == 0)) begin
        if (r_rt[idx] != '0) begin
          w_fr_mv[r_rt[idx]]   = 1'b1;
          w_fr_mtag[r_rt[idx]] = idx;
        end
        if (r_ct[idx] != '0) begin
          w_fr_cmv[r_ct[idx]]   = 1'b1;
          w_fr_cmtag[r_ct[idx]] = idx;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
  end
  assign bus.busy_o = 1'b0;
`else
  always_comb begin
    w_state_nxt = r_state;
    if (w_miss_hit)
      w_state_nxt = S_WALK;
    else if (r_state == S_WALK && r_ptr == r_missid)
      w_state_nxt = S_IDLE;
  end
  assign bus.busy_o = (r_state == S_WALK);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_missid <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_miss_hit) begin
        r_ptr    <= r_head;
        r_missid <= bus.missid_i;
      end else if (w_walk_act) begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v     <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_miss_hit) begin
        r_v     <= r_v & ~w_kill;
        r_tail  <= bus.missid_i + 1'b1;
        r_count <= {1'b0, w_miss_off} + 1'b1 - (TAGW+1)'(w_cmt_take);
      end else begin
        r_tail  <= r_tail + TAGW'(w_alloc_take);
        r_count <= r_count + (TAGW+1)'(w_alloc_take) - (TAGW+1)'(w_cmt_take);
      end
      if (w_alloc_take) begin
        r_v[r_tail]  <= 1'b1;
        r_rt[r_tail] <= bus.alloc_rt_i;
        r_ct[r_tail] <= bus.alloc_ct_i;
      end
      if (w_cmt_take) begin
        r_v[r_head] <= 1'b0;
        r_head      <= r_head + 1'b1;
      end
    end
  end

  // Later non-blocking writes win: walk insert, then retire clear, then alloc.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mv  <= '0;
      r_cmv <= '0;
    end else begin
      if (w_miss_hit) begin
`ifdef THOR2022_LT_FASTRECOVER_EN
        r_mv    <= w_fr_mv;
        r_mtag  <= w_fr_mtag;
        r_cmv   <= w_fr_cmv;
        r_cmtag <= w_fr_cmtag;
`else
        r_mv  <= '0;
        r_cmv <= '0;
`endif
      end else begin
        if (w_walk_ins) begin
          if (r_rt[r_ptr] != '0) begin
            r_mv[r_rt[r_ptr]]   <= 1'b1;
            r_mtag[r_rt[r_ptr]] <= r_ptr;
          end
          if (r_ct[r_ptr] != '0) begin
            r_cmv[r_ct[r_ptr]]   <= 1'b1;
            r_cmtag[r_ct[r_ptr]] <= r_ptr;
          end
        end
        if (w_cmt_take) begin
          if (w_rt_tag_eff == r_head) r_mv[w_h_rt]  <= 1'b0;
          if (w_ct_tag_eff == r_head) r_cmv[w_h_ct] <= 1'b0;
        end
      end
      if (w_alloc_take) begin
        if (bus.alloc_rt_i != '0) begin
          r_mv[bus.alloc_rt_i]   <= 1'b1;
          r_mtag[bus.alloc_rt_i] <= r_tail;
        end
        if (bus.alloc_ct_i != '0) begin
          r_cmv[bus.alloc_ct_i]   <= 1'b1;
          r_cmtag[bus.alloc_ct_i] <= r_tail;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lt  <= '0;
      r_clt <= '0;
    end else begin
      r_lt  <= r_mv & ~NREGS'(1);
      r_clt <= r_cmv & ~NCREGS'(1);
    end
  end

  assign bus.alloc_rdy_o     = w_alloc_rdy;
  assign bus.alloc_tag_o     = r_tail;
  assign bus.lk_valid_o      = r_mv[bus.lk_reg_i];
  assign bus.lk_tag_o        = r_mtag[bus.lk_reg_i];
  assign bus.livetarget_o    = r_lt;
  assign bus.ca_livetarget_o = r_clt;
  assign bus.count_o         = r_count;
  assign bus.state_o         = r_state;
endmodule
